// File: rtl/output_port_allocator.sv
// output_port_allocator
// Per-output-port packet allocator for a 5-port router (L, N, E, W, S).
// It grants this output to one input for a whole packet, from header to tail,
// using round-robin fairness. Flit transfer is gated by credit-based flow
// control toward the downstream buffer. A stall watchdog forces a release
// when a granted packet stops moving.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req[4:0]     flit present at input head (bit0=L, 1=N, 2=E, 3=W, 4=S)
//   flit_id[14:0] 3-bit flit type per input k at [3k+2:3k]
//                (001 header, 010 body, 100 tail, 101 single-flit packet)
//   credit_in    one-cycle pulse when the downstream buffer frees a slot
//   grant[4:0]   registered one-hot grant (crossbar select), 0 when idle
//   fire         combinational; the granted input's flit moves this cycle
//   credit_cnt   credits currently available
//   busy         registered; high while a packet holds the output
//   timeout_err  registered one-cycle pulse on a watchdog release
module output_port_allocator #(
    parameter int unsigned CREDITS  = 4,
    parameter int unsigned MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [14:0] flit_id,
    input  logic        credit_in,
    output logic [4:0]  grant,
    output logic        fire,
    output logic [2:0]  credit_cnt,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned N_PORTS = 5;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gidx;
    logic [HOLD_W-1:0]  stall_cnt;

    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] tail_bits;
    logic [N_PORTS-1:0] body_bits_unused;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               tail_hit;

    // (base + off) mod 5, valid for base <= 4 and off <= 5
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_PORTS) begin
            s = s - N_PORTS;
        end
        return IDX_W'(s);
    endfunction

    // Per-input decode of the flit type at each head
    always_comb begin
        eligible         = '0;
        tail_bits        = '0;
        body_bits_unused = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            eligible[k]         = req[k] & flit_id[ID_W*k];
            tail_bits[k]        = flit_id[ID_W*k + 2];
            body_bits_unused[k] = flit_id[ID_W*k + 1];
        end
    end

    // Round-robin search: scan farthest to nearest so the nearest eligible
    // input after rr_ptr is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = N_PORTS; i >= 1; i--) begin
            if (eligible[wrap_idx(rr_ptr, i)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(rr_ptr, i);
            end
        end
    end

    // grant is one-hot, so masking avoids indexing by gidx
    assign fire     = busy & (|(req & grant)) & (credit_cnt != '0);
    assign tail_hit = |(tail_bits & grant);

    // Allocation FSM, credit counter and stall watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            gidx        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= IDX_W'(N_PORTS - 1);
            stall_cnt   <= '0;
            credit_cnt  <= CNT_W'(CREDITS);
        end else begin
            timeout_err <= 1'b0;

            // A simultaneous fire and credit_in cancel out; the count saturates at CREDITS
            if (fire && !credit_in) begin
                credit_cnt <= credit_cnt - CNT_W'(1);
            end else if (!fire && credit_in && (credit_cnt != CNT_W'(CREDITS))) begin
                credit_cnt <= credit_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= LOCKED;
                        grant     <= N_PORTS'(1) << win_idx;
                        gidx      <= win_idx;
                        busy      <= 1'b1;
                        stall_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (fire) begin
                        if (tail_hit) begin
                            state  <= IDLE;
                            grant  <= '0;
                            busy   <= 1'b0;
                            rr_ptr <= gidx;
                        end else begin
                            stall_cnt <= '0;
                        end
                    end else if (stall_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        // Watchdog: the packet stalled too long, so give up the output
                        state       <= IDLE;
                        grant       <= '0;
                        busy        <= 1'b0;
                        rr_ptr      <= gidx;
                        timeout_err <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator
// Self-checking bench for output_port_allocator. A behavioural model tracks
// the expected grant, busy, credits, timeout and fire. Every cycle it is
// compared against the DUT on the falling edge. Directed scenarios add
// hand-computed literal checks. A randomized phase then follows.
module tb_output_port_allocator;

    localparam int CREDITS  = 4;
    localparam int MAX_HOLD = 8;

    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] B = 3'b010;
    localparam logic [2:0] T = 3'b100;
    localparam logic [2:0] S = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  req = '0;
    logic [14:0] flit_id = '0;
    logic        credit_in = 1'b0;
    logic [4:0]  grant;
    logic        fire;
    logic [2:0]  credit_cnt;
    logic        busy;
    logic        timeout_err;

    output_port_allocator #(.CREDITS(CREDITS), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .flit_id     (flit_id),
        .credit_in   (credit_in),
        .grant       (grant),
        .fire        (fire),
        .credit_cnt  (credit_cnt),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model state
    bit m_busy;
    int m_g;
    int m_rr;
    int m_cred;
    int m_stall;
    bit m_to;
    bit m_fire;

    task automatic model_step();
        int  p;
        bit  found;
        m_to = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int i = 1; i <= 5; i++) begin
                p = (m_rr + i) % 5;
                if (!found && req[p] && flit_id[3*p]) begin
                    found = 1'b1;
                    m_g   = p;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_stall = 0;
            end
        end else if (m_fire) begin
            if (flit_id[3*m_g + 2]) begin
                m_busy = 1'b0;
                m_rr   = m_g;
            end else begin
                m_stall = 0;
            end
        end else begin
            m_stall = m_stall + 1;
            if (m_stall == MAX_HOLD) begin
                m_busy = 1'b0;
                m_rr   = m_g;
                m_to   = 1'b1;
            end
        end
        if (m_fire && !credit_in) begin
            m_cred = m_cred - 1;
        end else if (!m_fire && credit_in && m_cred < CREDITS) begin
            m_cred = m_cred + 1;
        end
    endtask

    // Compare process: outputs against the model on every falling edge
    always @(negedge clk) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_g     = 0;
            m_rr    = 4;
            m_cred  = CREDITS;
            m_stall = 0;
            m_to    = 1'b0;
        end
        m_fire = m_busy && req[m_g] && (m_cred > 0);
        chk("model_grant", 32'(grant), m_busy ? (32'd1 << m_g) : 32'd0);
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_timeout", 32'(timeout_err), 32'(m_to));
        chk("model_credit", 32'(credit_cnt), 32'(m_cred));
        chk("model_fire", 32'(fire), 32'(m_fire));
        if (rst) begin
            model_step();
        end
    end

    function automatic logic [14:0] fid(input int k, input logic [2:0] t);
        logic [14:0] v;
        v = 15'(t) << (3*k);
        return v;
    endfunction

    // Drive one cycle of inputs, sample fire before the edge, return after it
    task automatic cyc(input logic [4:0] r, input logic [14:0] f, input logic ci,
                       output logic fo);
        req       = r;
        flit_id   = f;
        credit_in = ci;
        #1 fo = fire;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        flit_id   = '0;
        credit_in = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic        f;
        int          fc;
        logic [31:0] exp_g [11];
        logic [4:0]  rr;
        logic [14:0] rf;

        @(posedge clk);
        #1;

        // Reset values and a three-flit packet from L
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_credit", 32'(credit_cnt), CREDITS);
        cyc(5'b00001, fid(0, H), 1'b0, f);
        chk("t1_idle_fire", 32'(f), 0);
        chk("t1_grant", 32'(grant), 1);
        cyc(5'b00001, fid(0, H), 1'b0, f);
        chk("t1_fire_hdr", 32'(f), 1);
        cyc(5'b00001, fid(0, B), 1'b0, f);
        chk("t1_fire_body", 32'(f), 1);
        cyc(5'b00001, fid(0, T), 1'b0, f);
        chk("t1_fire_tail", 32'(f), 1);
        chk("t1_grant_after", 32'(grant), 0);
        chk("t1_credit", 32'(credit_cnt), 1);

        // Round-robin over all five inputs with single-flit packets
        do_reset();
        exp_g = '{32'd1, 32'd0, 32'd2, 32'd0, 32'd4, 32'd0, 32'd8, 32'd0, 32'd16, 32'd0, 32'd1};
        for (int i = 0; i < 11; i++) begin
            cyc(5'b11111, 15'b101101101101101, 1'b1, f);
            chk($sformatf("t2_rr_grant%0d", i), 32'(grant), exp_g[i]);
        end
        chk("t2_credit", 32'(credit_cnt), CREDITS);

        // Credit exhaustion on a 6-flit packet from E
        do_reset();
        fc = 0;
        cyc(5'b00100, fid(2, H), 1'b0, f);
        chk("t3_grant", 32'(grant), 4);
        cyc(5'b00100, fid(2, H), 1'b0, f);
        fc += int'(f);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b00100, fid(2, B), 1'b0, f);
            fc += int'(f);
        end
        chk("t3_four_fires", 32'(fc), 4);
        chk("t3_credit_zero", 32'(credit_cnt), 0);
        cyc(5'b00100, fid(2, B), 1'b0, f);
        chk("t3_no_fire_at_zero", 32'(f), 0);
        cyc(5'b00100, fid(2, B), 1'b1, f);
        chk("t3_no_fire_credit_cycle", 32'(f), 0);
        chk("t3_credit_one", 32'(credit_cnt), 1);
        cyc(5'b00100, fid(2, B), 1'b0, f);
        chk("t3_one_more_fire", 32'(f), 1);
        cyc(5'b00100, fid(2, T), 1'b0, f);
        chk("t3_tail_blocked", 32'(f), 0);
        chk("t3_still_busy", 32'(busy), 1);
        cyc(5'b00100, fid(2, T), 1'b1, f);
        cyc(5'b00100, fid(2, T), 1'b0, f);
        chk("t3_tail_fire", 32'(f), 1);
        chk("t3_release", 32'(grant), 0);

        // Simultaneous fire and credit_in, then saturation
        do_reset();
        cyc(5'b00001, fid(0, H), 1'b0, f);
        cyc(5'b00001, fid(0, H), 1'b0, f);
        cyc(5'b00001, fid(0, B), 1'b0, f);
        chk("t4_credit_two", 32'(credit_cnt), 2);
        cyc(5'b00001, fid(0, B), 1'b1, f);
        chk("t4_fire_and_credit", 32'(f), 1);
        chk("t4_credit_hold", 32'(credit_cnt), 2);
        cyc(5'b00001, fid(0, T), 1'b1, f);
        cyc(5'b00000, 15'd0, 1'b1, f);
        cyc(5'b00000, 15'd0, 1'b1, f);
        chk("t4_credit_full", 32'(credit_cnt), 4);
        cyc(5'b00000, 15'd0, 1'b1, f);
        chk("t4_credit_sat", 32'(credit_cnt), 4);

        // Watchdog release after MAX_HOLD stall cycles on W
        do_reset();
        cyc(5'b01000, fid(3, H), 1'b0, f);
        chk("t5_grant_w", 32'(grant), 8);
        for (int i = 1; i <= MAX_HOLD; i++) begin
            cyc(5'b00000, 15'd0, 1'b0, f);
            if (i == MAX_HOLD - 1) begin
                chk("t5_busy_before", 32'(busy), 1);
                chk("t5_no_timeout_yet", 32'(timeout_err), 0);
            end
        end
        chk("t5_released", 32'(grant), 0);
        chk("t5_timeout", 32'(timeout_err), 1);
        cyc(5'b11111, 15'b001001001001001, 1'b0, f);
        chk("t5_timeout_pulse", 32'(timeout_err), 0);
        chk("t5_next_is_s", 32'(grant), 16);

        // Asynchronous reset in the middle of a packet on N
        do_reset();
        cyc(5'b00010, fid(1, H), 1'b0, f);
        chk("t6_grant_n", 32'(grant), 2);
        cyc(5'b00010, fid(1, H), 1'b0, f);
        cyc(5'b00010, fid(1, B), 1'b0, f);
        req     = 5'b00010;
        flit_id = fid(1, B);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_fire", 32'(fire), 0);
        chk("t6_async_credit", 32'(credit_cnt), CREDITS);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(5'b00011, fid(0, H) | fid(1, H), 1'b0, f);
        chk("t6_l_first", 32'(grant), 1);

        // Randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rr = 5'($urandom);
            rf = '0;
            for (int k = 0; k < 5; k++) begin
                case ($urandom % 4)
                    0: rf |= fid(k, H);
                    1: rf |= fid(k, B);
                    2: rf |= fid(k, T);
                    default: rf |= fid(k, S);
                endcase
            end
            rst = ($urandom % 400 == 0) ? 1'b0 : 1'b1;
            cyc(rr, rf, ($urandom % 3 == 0) ? 1'b1 : 1'b0, f);
        end
        rst = 1'b1;
        cyc(5'b00000, 15'd0, 1'b0, f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
